// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply host link: sizes, header code,
// controller state encodings and the header byte helper.
package matmul_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int MAX_N_DEF  = 8;
  localparam int ADDR_W_DEF = 6;

  localparam logic [7:0] HDR_ERR = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WAIT,
    S_FETCH,
    S_LOAD,
    S_BYTE,
    S_FIN
  } state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_ACK,
    HS_DRAIN
  } hs_state_t;

  function automatic logic [7:0] hdr_byte(input logic [3:0] n, input logic bad);
    return bad ? HDR_ERR : {4'h0, n};
  endfunction

endpackage

// File: rtl/result_sender_tx_byte_handshake.sv
// One-byte handshake with the UART TX: registers tx_start/tx_data, then waits
// for tx_busy to rise and fall before reporting byte_done.
module tx_byte_handshake
  import matmul_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] byte_in,
  input  logic       tx_busy,
  output logic       accept,
  output logic       byte_done,
  output logic       tx_start,
  output logic [7:0] tx_data
);

  hs_state_t hs, hs_nx;

  assign accept    = (hs == HS_IDLE) && send && !tx_busy;
  assign byte_done = (hs == HS_DRAIN) && !tx_busy;

  always_comb begin
    hs_nx = hs;
    case (hs)
      HS_IDLE:  if (accept)  hs_nx = HS_ACK;
      HS_ACK:   if (tx_busy) hs_nx = HS_DRAIN;
      HS_DRAIN: if (!tx_busy) hs_nx = HS_IDLE;
      default:  hs_nx = HS_IDLE;
    endcase
  end

  // tx_data only follows byte_in while idle, so it is frozen for the whole
  // time the UART owns the byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs       <= HS_IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      hs       <= hs_nx;
      tx_start <= accept;
      if (hs == HS_IDLE && send) tx_data <= byte_in;
    end
  end

endmodule

// File: rtl/result_sender.sv
// Streams the result matrix to the host: size header, then each element in
// row-major order, MSB byte first, through tx_byte_handshake.
//
// state   | meaning
// IDLE    | waiting for start
// HDR     | offering the header byte
// WAIT    | byte in flight (handshake ACK/DRAIN), ret_hdr picks what follows
// FETCH   | rd_en pulse for element elem_idx
// LOAD    | capture rd_data into the shift register
// BYTE    | offering the current element byte
// FIN     | done pulse
module result_sender
  import matmul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_N  = MAX_N_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        matrix_size,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              size_err
);

  localparam int NB = DATA_W / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int EW = ADDR_W + 1;
  localparam logic [4:0] MAX_N5 = 5'(MAX_N);

  state_t            state, state_nx;
  logic [3:0]        n_q;
  logic [7:0]        nn_q;
  logic [EW-1:0]     elem_idx;
  logic [BW-1:0]     byte_idx;
  logic              ret_hdr;
  logic [DATA_W-1:0] shreg;
  logic [7:0]        ms8;

  logic       send, accept, byte_done;
  logic       n_bad, last_byte, last_elem;
  logic [7:0] byte_sel;

  assign ms8       = {4'h0, matrix_size};
  assign n_bad     = {1'b0, n_q} > MAX_N5;
  assign last_byte = byte_idx == BW'(NB - 1);
  assign last_elem = (9'(elem_idx) + 9'd1) == {1'b0, nn_q};
  assign send      = (state == S_HDR) || (state == S_BYTE);
  assign byte_sel  = (state == S_HDR) ? hdr_byte(n_q, n_bad) : shreg[DATA_W-1 -: 8];
  assign rd_addr   = elem_idx[ADDR_W-1:0];

  tx_byte_handshake u_hs (
    .clk       (clk),
    .rst       (rst),
    .send      (send),
    .byte_in   (byte_sel),
    .tx_busy   (tx_busy),
    .accept    (accept),
    .byte_done (byte_done),
    .tx_start  (tx_start),
    .tx_data   (tx_data)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_HDR;
      S_HDR:   if (accept) state_nx = S_WAIT;
      S_BYTE:  if (accept) state_nx = S_WAIT;
      S_WAIT: begin
        if (byte_done) begin
          if (ret_hdr)         state_nx = (n_q == 4'd0 || n_bad) ? S_FIN : S_FETCH;
          else if (!last_byte) state_nx = S_BYTE;
          else if (!last_elem) state_nx = S_FETCH;
          else                 state_nx = S_FIN;
        end
      end
      S_FETCH: state_nx = S_LOAD;
      S_LOAD:  state_nx = S_BYTE;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      n_q      <= 4'd0;
      nn_q     <= 8'd0;
      elem_idx <= '0;
      byte_idx <= '0;
      ret_hdr  <= 1'b0;
      shreg    <= '0;
      rd_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      size_err <= 1'b0;
    end else begin
      state <= state_nx;
      rd_en <= (state_nx == S_FETCH);
      done  <= (state_nx == S_FIN);
      busy  <= (state_nx != S_IDLE) && (state_nx != S_FIN);
      case (state)
        S_IDLE: begin
          if (start) begin
            n_q      <= matrix_size;
            nn_q     <= ms8 * ms8;
            elem_idx <= '0;
            byte_idx <= '0;
            size_err <= 1'b0;
          end
        end
        S_HDR:  if (accept) ret_hdr <= 1'b1;
        S_BYTE: if (accept) ret_hdr <= 1'b0;
        S_WAIT: begin
          if (byte_done) begin
            if (ret_hdr) begin
              if (n_bad) size_err <= 1'b1;
            end else if (!last_byte) begin
              byte_idx <= byte_idx + BW'(1);
              shreg    <= shreg << 8;
            end else if (!last_elem) begin
              elem_idx <= elem_idx + EW'(1);
            end
          end
        end
        S_LOAD: begin
          shreg    <= rd_data;
          byte_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/result_sender.md
Name: result_sender

Overview:
Streams the product matrix back to the host over the UART transmitter; it is the transmit-side counterpart of the receive path in the control unit. On start it sends a one-byte header carrying the matrix size. It then reads each result element, in row-major order, from the result buffer's synchronous read port and serialises it MSB byte first. Each byte is handed to the UART TX with a tx_start/tx_busy handshake.

Parameters:
DATA_W, 16, result element width in bits; must be a multiple of 8.
MAX_N, 8, largest legal matrix dimension.
ADDR_W, 6, result buffer address width; must satisfy 2^ADDR_W >= MAX_N*MAX_N.

Ports:
clk  in  1  system clock.
rst  in  1  reset; synchronous, active-high. Single clock domain.
start  in  1  one-cycle request to begin sending; sampled only in IDLE.
matrix_size  in  4  dimension N; sampled on an accepted start.
rd_addr  out  ADDR_W  result buffer read address; row-major index i*N+j.
rd_en  out  1  read strobe; rd_data is valid on the cycle after rd_en.
rd_data  in  DATA_W  result element.
tx_data  out  8  byte to the UART TX; held stable from tx_start until tx_busy falls.
tx_start  out  1  one-cycle pulse; issued only while tx_busy=0.
tx_busy  in  1  UART TX busy; rises the cycle after tx_start and stays high until the byte completes.
busy  out  1  high from an accepted start until done.
done  out  1  one-cycle pulse after the last byte completes.
size_err  out  1  sticky; set when N>MAX_N is requested; cleared by the next accepted start.

Behaviour:
- Reset: state=IDLE. rd_addr, rd_en, tx_data, tx_start, busy, done and size_err are all 0. Counters are cleared.
- Reset mid-transfer: return to IDLE next cycle with no further tx_start. Any byte already in the UART finishes independently.
- States:
  - IDLE: on start, latch N, assert busy, clear size_err, go to HDR.
  - HDR: tx_data = {4'h0,N}, or 8'hFF if N>MAX_N. Wait for tx_busy=0, then pulse tx_start and go to ACK with ret=HDR.
  - ACK: wait for tx_busy=1, then go to DRAIN.
  - DRAIN: wait for tx_busy=0, then select the next state from ret:
    - ret=HDR and (N=0 or N>MAX_N): go to FIN; set size_err if N>MAX_N.
    - ret=HDR, otherwise: go to FETCH.
    - ret=BYTE and more bytes remain in the element: advance the byte index, go to BYTE.
    - ret=BYTE, element finished, more elements remain: advance the element index, go to FETCH.
    - ret=BYTE, element finished, last element: go to FIN.
  - FETCH: drive rd_addr=elem_idx, pulse rd_en, go to LOAD.
  - LOAD: capture rd_data into the shift register, go to BYTE.
  - BYTE: tx_data = current byte, MSB byte first. Pulse tx_start when tx_busy=0, go to ACK with ret=BYTE.
  - FIN: pulse done, drop busy, go to IDLE.
- Counters:
  - elem_idx width is ADDR_W+1 and counts 0..N*N-1.
  - N*N is computed once at start into an 8-bit register.
  - byte_idx counts 0..DATA_W/8-1.
- Boundary conditions:
  - start while busy: ignored; no queueing.
  - tx_busy already high in HDR or BYTE: hold tx_data and wait; no tx_start.
  - N=0: header 0x00 only, then done.
  - N=MAX_N: exactly MAX_N^2 elements; last rd_addr = MAX_N^2-1; no wrap.
- Latency: start to first tx_start is 2 cycles when tx_busy=0. Each element costs 2 read cycles plus DATA_W/8 byte handshakes.
- Sizing: total bytes = 1 + N*N*DATA_W/8.

Decomposition:
- Shared package (matmul_pkg): state encoding localparams; MAX_N; header error code 8'hFF; DATA_W default.
- One sub-module: tx_byte_handshake. It owns the tx_start pulse plus the ACK/DRAIN wait and returns byte_done; result_sender sequences the header and elements around it.

Test Plan:
- N=2, buffer {0x1234,0xABCD,0x0001,0xFF00}, UART model busy 10 cycles per byte -> bytes 02,12,34,AB,CD,00,01,FF,00; rd_addr 0..3; one done pulse.
- N=0 -> single byte 00, done, no rd_en ever.
- N=9 (MAX_N=8) -> single byte FF, size_err=1, no rd_en; a following start with N=1 clears size_err and sends 01 then 2 data bytes.
- tx_busy held high for 50 cycles at start -> no tx_start until it falls; tx_data stable throughout; start pulses while busy are ignored.
- rst asserted after the 3rd byte of an N=3 transfer -> all outputs 0 the next cycle; a subsequent N=1 transfer is correct.
- N=8, value = address -> 129 bytes total, last rd_addr=63, elem_idx never wraps.
